// File: rtl/gpio_tx_if.sv
// gpio_tx_if: HACK CPU data-bus view seen by the serial transmitter.
//   addressM : CPU data address (15 bits)
//   outM     : CPU write data (16 bits)
//   writeM   : CPU write strobe
//   statusM  : status word returned by the transmitter, {13'b0, overrun, full, busy}
// master = CPU side, slave = transmitter side.
interface gpio_tx_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] statusM;

  modport master (output addressM, output outM, output writeM, input statusM);
  modport slave  (input addressM, input outM, input writeM, output statusM);
endinterface

// File: rtl/gpio_tx.sv
// gpio_tx: memory-mapped 8N1 serial transmitter driving the GPIO pin.
//   CLK  : system clock, all state changes on the rising edge
//   RST  : synchronous reset, active low
//   bus  : CPU bus (slave modport); a write to DATA_ADDR queues outM[7:0]
//          into a 4-entry FIFO, a write to STAT_ADDR with outM[2] set clears
//          the sticky overrun flag; statusM = {13'b0, overrun, full, busy}
//   TX   : serial line, idle high, registered
module gpio_tx #(
  parameter int          CLKS_PER_BIT = 139,
  parameter logic [14:0] DATA_ADDR    = 15'h6002,
  parameter logic [14:0] STAT_ADDR    = 15'h6003
) (
  input  logic      CLK,
  input  logic      RST,
  gpio_tx_if.slave  bus,
  output logic      TX
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    mem_q [4];

  logic push_req, clr_req, full, empty, bit_end, pop, push, overflow, busy;

  assign push_req = bus.writeM && (bus.addressM == DATA_ADDR);
  assign clr_req  = bus.writeM && (bus.addressM == STAT_ADDR) && bus.outM[2];
  assign full     = (count_q == 3'd4);
  assign empty    = (count_q == 3'd0);
  assign bit_end  = (timer_q == BIT_LAST);
  // A pop happens from IDLE, or at the last stop-bit cycle so the next
  // start bit follows with no idle gap.
  assign pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  // A full FIFO still accepts a byte when a slot frees in the same cycle.
  assign push     = push_req && (!full || pop);
  assign overflow = push_req && !push;
  assign busy     = (state_q != IDLE) || !empty;

  assign bus.statusM = {13'b0, overrun_q, full, busy};
  assign TX          = tx_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = bit_end ? '0 : timer_q + TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    wr_ptr_d  = wr_ptr_q + {1'b0, push};
    rd_ptr_d  = rd_ptr_q + {1'b0, pop};
    count_d   = count_q + {2'b0, push} - {2'b0, pop};
    // Set has priority over a clear in the same cycle.
    overrun_d = overflow ? 1'b1 : (clr_req ? 1'b0 : overrun_q);
    // TX follows the state one cycle later, so it never sees writeM directly.
    tx_d      = (state_q == START) ? 1'b0 :
                (state_q == DATA)  ? shift_q[0] : 1'b1;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pop) begin
          state_d = START;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_ptr_q];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage carries no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (RST && push) mem_q[wr_ptr_q] <= bus.outM[7:0];
  end

endmodule

// File: tb/tb_gpio_tx.sv
module tb_gpio_tx;
  localparam logic [14:0] DA = 15'h6002;
  localparam logic [14:0] SA = 15'h6003;

  logic CLK;
  logic RST;
  logic TX;
  int   cyc;

  gpio_tx_if bus();

  gpio_tx #(.CLKS_PER_BIT(4), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .TX(TX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];
  int         start_cyc [$];
  int         frames_started = 0;
  bit         full_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: decodes 8N1 at CLKS_PER_BIT=4, sampling bit centers.
  bit         in_frame = 0;
  int         mcnt = 0;
  logic [9:0] bits;
  always @(negedge CLK) begin
    if (bus.statusM[1]) full_seen = 1;
    if (!RST) begin
      in_frame = 0;
      mcnt     = 0;
    end else if (!in_frame) begin
      if (TX == 1'b0) begin
        in_frame = 1;
        mcnt     = 0;
        bits     = '0;
        frames_started++;
        start_cyc.push_back(cyc);
      end
    end else begin
      mcnt++;
    end
    if (in_frame && (mcnt % 4 == 2)) bits[mcnt/4] = TX;
    if (in_frame && mcnt == 39) begin
      in_frame = 0;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got %03h expected none", bits);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("frame: line bits %03h data %02h expected %02h", bits, bits[8:1], e);
        check("frame_bits", {22'b0, bits}, {22'b0, 1'b1, e, 1'b0});
      end
    end
  end

  task automatic bus_write(input logic [14:0] a, input logic [15:0] d, input logic we);
    bus.addressM = a;
    bus.outM     = d;
    bus.writeM   = we;
    @(posedge CLK); #1;
    bus.writeM   = 1'b0;
    bus.addressM = 15'h0;
    bus.outM     = 16'h0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame || bus.statusM[0]) && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: drain timeout, %0d bytes pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic watch_idle(input int n, input string name);
    bit ok;
    ok = 1;
    repeat (n) begin
      @(negedge CLK);
      if (TX !== 1'b1) ok = 0;
    end
    @(posedge CLK); #1;
    check(name, {31'b0, ok}, 32'd1);
  endtask

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic        we;
    logic [15:0] mask;
    logic [15:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [6];

  task automatic apply_vec(input int i);
    bus_write(vecs[i].addr, vecs[i].data, vecs[i].we);
    $display("vec %0d %s: addr %04h data %04h we %0d status %04h", i, vecs[i].name,
             vecs[i].addr, vecs[i].data, vecs[i].we, bus.statusM);
    check(vecs[i].name, {16'b0, bus.statusM & vecs[i].mask}, {16'b0, vecs[i].exp});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int push_cyc;
    int f0;
    int n;

    vecs[0] = '{SA,          16'h0003, 1'b1, 16'h0004, 16'h0004, "clr_without_bit2"};
    vecs[1] = '{SA,          16'h0004, 1'b0, 16'h0004, 16'h0004, "clr_without_we"};
    vecs[2] = '{15'h6001,    16'h0004, 1'b1, 16'h0004, 16'h0004, "clr_wrong_addr"};
    vecs[3] = '{SA,          16'h0004, 1'b1, 16'h0004, 16'h0000, "overrun_clear"};
    vecs[4] = '{DA + 15'd2,  16'h0055, 1'b1, 16'hFFFF, 16'h0000, "decode_addr"};
    vecs[5] = '{DA,          16'h0055, 1'b0, 16'hFFFF, 16'h0000, "decode_we"};

    RST = 1'b0;
    bus.addressM = 15'h0;
    bus.outM     = 16'h0;
    bus.writeM   = 1'b0;

    // 1. reset values
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    check("reset_tx", {31'b0, TX}, 32'd1);
    check("reset_status", {16'b0, bus.statusM}, 32'h0);
    watch_idle(50, "reset_idle_tx");

    // 2. single byte
    start_cyc.delete();
    exp_q.push_back(8'hA5);
    bus_write(DA, 16'h00A5, 1'b1);
    push_cyc = cyc;
    check("busy_after_push", {31'b0, bus.statusM[0]}, 32'd1);
    wait_drain(80, "single_drain");
    check("single_busy_drop", {16'b0, bus.statusM}, 32'h0);
    check("single_start_latency", start_cyc.size() > 0 ? start_cyc[0] - push_cyc : -1, 32'd2);

    // 3. back-to-back stream
    start_cyc.delete();
    full_seen = 0;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      bus_write(DA, 16'(i), 1'b1);
    end
    wait_drain(200, "stream_drain");
    check("stream_frames", start_cyc.size(), 32'd3);
    if (start_cyc.size() == 3) begin
      check("stream_gap_1", start_cyc[1] - start_cyc[0], 32'd40);
      check("stream_gap_2", start_cyc[2] - start_cyc[1], 32'd40);
    end
    check("stream_never_full", {31'b0, full_seen}, 32'd0);

    // 4. overrun and clear: 6 writes, the 6th is dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
      bus_write(DA, 16'h0010 + 16'(i), 1'b1);
      if (i == 4) check("full_status", {16'b0, bus.statusM}, 32'h0003);
      if (i == 5) check("overrun_status", {16'b0, bus.statusM}, 32'h0007);
    end
    for (int i = 0; i < 4; i++) apply_vec(i);
    wait_drain(400, "overrun_drain");
    check("overrun_idle_status", {16'b0, bus.statusM}, 32'h0);

    // 5. reset mid-frame
    f0 = frames_started;
    exp_q.push_back(8'hFF);
    bus_write(DA, 16'h00FF, 1'b1);
    bus_write(DA, 16'h0011, 1'b1);
    bus_write(DA, 16'h0022, 1'b1);
    n = 0;
    while (frames_started == f0 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check("midframe_started", frames_started, f0 + 1);
    repeat (16) @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    @(posedge CLK); #1;
    check("midframe_reset_tx", {31'b0, TX}, 32'd1);
    check("midframe_reset_status", {16'b0, bus.statusM}, 32'h0);
    bus_write(DA, 16'h0033, 1'b1);
    RST = 1'b1;
    watch_idle(100, "midframe_no_frames_tx");
    check("midframe_frame_count", frames_started, f0 + 1);
    check("midframe_status_after", {16'b0, bus.statusM}, 32'h0);

    // 6. address decode
    for (int i = 4; i < 6; i++) apply_vec(i);
    watch_idle(60, "decode_tx_idle");
    check("decode_frame_count", frames_started, f0 + 1);

    // upper byte of outM is ignored
    exp_q.push_back(8'h5A);
    bus_write(DA, 16'hAB5A, 1'b1);
    wait_drain(80, "upper_byte_drain");
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
